uart_frame_decoder: RTL

Parametrised UART receive decoder for the logic-analyzer capture path. It supersedes the fixed 8-bit decoder and adds several capabilities:
- configurable data width, oversampling ratio, parity and stop-bit count
- an input synchroniser
- start-bit glitch rejection
- framing and parity error reporting

It sits between the probe pin and the capture/trace logic. It emits one decoded word per frame, plus a detect pulse for trigger logic.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sync.sv | 37 +++
 rtl/uart_frame_decoder.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state encoding, parity mode constants and a counter-width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Bits needed for a counter that runs 0..n-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the raw serial line plus falling-edge detect.
// Latency: rxs_o follows rx_i after 2 clk cycles; fall_o is coincident with the first low rxs_o.
// Backpressure: none; free-running.
//
// Ports:
//   clk, rst_n - system clock, async active-low reset (all flops reset to 1 = line idle)
//   rx_i       - raw, asynchronous serial input
//   rxs_o      - synchronised line value
//   fall_o     - 1 when rxs_o has just gone from 1 to 0
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rxs_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rxs_o  = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_frame_decoder.sv
// Parametrised UART receive decoder: one decoded word per frame plus a frame-detect pulse.
// Latency: pulses one cycle after the last stop-bit decision (+1 more with majority voting).
// Backpressure: none; outputs are single-cycle pulses, consumer must keep up.
//
// Ports:
//   clk, rst_n      - system clock, async active-low reset
//   rx              - raw serial line (async, idles high)
//   enable          - low forces IDLE and blocks new starts
//   detect_only     - high suppresses valid/out_data update at frame end
//   out_data        - last error-free word, LSB = first data bit received
//   valid           - pulse: out_data just updated
//   detected        - pulse: a frame ended (errors or not)
//   frame_err       - pulse: a stop bit sampled low
//   parity_err      - pulse: parity mismatch
//   busy            - state != IDLE
//
// Optional build macro: UART_DEC_MAJORITY_EN - 2-of-3 majority vote around each sample point.
module uart_frame_decoder
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 enable,
  input  logic                 detect_only,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 valid,
  output logic                 detected,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int IW = 4;
  localparam logic [CW-1:0] CNT_LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF      = CW'(CLKS_PER_BIT / 2);
  localparam logic [IW-1:0] IDX_DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic          ODD_INV       = (PARITY_MODE == PARITY_ODD);

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic rxs;
  logic rx_fall;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_i   (rx),
    .rxs_o  (rxs),
    .fall_o (rx_fall)
  );

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   armed_q, armed_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic [DATA_BITS-1:0]   out_data_q, out_data_d;
  logic                   valid_q, valid_d;
  logic                   det_q, det_d;
  logic                   fe_q, fe_d;
  logic                   pe_q, pe_d;

  // sample: a bit decision is taken this cycle; bit_val: the decided bit value.
  logic sample;
  logic bit_val;

`ifdef UART_DEC_MAJORITY_EN
  localparam logic [CW-1:0] CNT_PRE = CW'(CLKS_PER_BIT - 2);

  // Votes at CLKS_PER_BIT-2 and -1 are stored; the third vote is the live
  // rxs on the cycle after reload, so every decision lands one cycle late.
  logic vote0_q;
  logic vote1_q;
  logic pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vote0_q <= 1'b1;
      vote1_q <= 1'b1;
      pend_q  <= 1'b0;
    end else begin
      if (cnt_q == CNT_PRE)  vote0_q <= rxs;
      if (cnt_q == CNT_LAST) vote1_q <= rxs;
      pend_q <= (state_q != IDLE) && enable && (cnt_q == CNT_LAST);
    end
  end

  assign sample  = pend_q;
  assign bit_val = (vote0_q & vote1_q) | (vote0_q & rxs) | (vote1_q & rxs);
`else
  assign sample  = (cnt_q == CNT_LAST);
  assign bit_val = rxs;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable && armed_q && rx_fall) state_d = START;
      end
      START: begin
        // A start bit that is high at its centre was a glitch.
        if (sample) state_d = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (sample && (idx_q == IDX_DATA_LAST)) begin
          state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (sample) state_d = STOP;
      end
      STOP: begin
        if (sample && (idx_q == IDX_STOP_LAST)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    armed_d    = armed_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    out_data_d = out_data_q;
    valid_d    = 1'b0;
    det_d      = 1'b0;
    fe_d       = 1'b0;
    pe_d       = 1'b0;

    // Entering START preloads half a bit so later samples hit bit centres.
    if (state_q == IDLE) begin
      cnt_d = (state_d == START) ? CNT_HALF : '0;
    end else if (!enable) begin
      cnt_d = '0;
    end else begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end

    if ((state_q == IDLE) && rxs) armed_d = 1'b1;

    if (!enable) begin
      idx_d  = '0;
      perr_d = 1'b0;
      ferr_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          idx_d  = '0;
          perr_d = 1'b0;
          ferr_d = 1'b0;
        end
        START: begin
          if (sample) idx_d = '0;
        end
        DATA: begin
          if (sample) begin
            shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
            idx_d   = (idx_q == IDX_DATA_LAST) ? '0 : idx_q + 1'b1;
          end
        end
        PARITY: begin
          if (sample && (bit_val != ((^shift_q) ^ ODD_INV))) perr_d = 1'b1;
        end
        STOP: begin
          if (sample) begin
            if (!bit_val) ferr_d = 1'b1;
            if (idx_q == IDX_STOP_LAST) begin
              idx_d = '0;
              det_d = 1'b1;
              fe_d  = ferr_q | ~bit_val;
              pe_d  = perr_q;
              if (!detect_only && !(ferr_q | ~bit_val) && !perr_q) begin
                out_data_d = shift_q;
                valid_d    = 1'b1;
              end
              // A line still low here is a break; wait for it to return high.
              armed_d = rxs;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: idx_d = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      armed_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      out_data_q <= '0;
      valid_q    <= 1'b0;
      det_q      <= 1'b0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      armed_q    <= armed_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      out_data_q <= out_data_d;
      valid_q    <= valid_d;
      det_q      <= det_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
    end
  end

  assign out_data   = out_data_q;
  assign valid      = valid_q;
  assign detected   = det_q;
  assign frame_err  = fe_q;
  assign parity_err = pe_q;
  assign busy       = (state_q != IDLE);

endmodule
